uart_rx_byte: RTL and testbench

- UART receiver that sits directly upstream of the character counter.
- Converts the asynchronous serial line into 8-bit bytes, each presented with a one-cycle valid strobe that drives the counter's data and enable inputs.
- Fixed 8N1 framing, LSB first.
- Oversampled bit recovery with start-bit glitch rejection and framing-error reporting.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 17 +
 rtl/uart_rx_byte.sv | 114 +++++++++++
 tb/tb_uart_rx_byte.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, frame constants and baud divider helper for the UART blocks
// Contents: uart_state_t (IDLE, START, DATA, STOP, BRK_WAIT), DATA_BITS, baud_div().
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} uart_state_t;
   localparam int DATA_BITS = 8;
   function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
      int d;
      d = clk_freq / (baud * oversample);
      return (d < 1) ? 1 : d;
   endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: emits a one-cycle oversample tick every DIV clocks, phase restartable
// Ports: clk, rst (sync, active-high), restart (zero the phase counter), tick (one-cycle strobe).
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);
   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk)
      r_cnt <= (rst || restart || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
   assign tick = r_cnt == LAST;
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampled 8N1 UART receiver with start-glitch rejection and framing-error strobe
// Ports: clk, rst (sync, active-high), rx (async serial, idle high),
//        dout (last good byte), dout_valid (1-cycle strobe), frame_err (1-cycle strobe), busy.
// Option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions around each nominal sample.
module uart_rx_byte #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       dout_valid,
   output logic       frame_err,
   output logic       busy
);
   import uart_pkg::*;
   localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] HALF_NOM = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_NOM = SW'(OVERSAMPLE - 1);
   logic r_sync1, r_sync2;
   uart_state_t r_state;
   logic [SW-1:0] r_scnt;
   logic [IW-1:0] r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic w_tick, w_restart, w_rxs, w_nom, w_dec_en, w_dec_bit;
   logic [SW-1:0] w_nom_cnt;
   assign w_rxs = r_sync2;
   assign w_restart = r_state == IDLE && !w_rxs;
   assign w_nom_cnt = (r_state == START) ? HALF_NOM : FULL_NOM;
   assign w_nom = w_tick && r_scnt == w_nom_cnt && (r_state inside {START, DATA, STOP});
   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk(clk),
      .rst(rst),
      .restart(w_restart),
      .tick(w_tick)
   );
`ifdef UART_RX_MAJORITY_EN
   // The decision lands one tick after the nominal sample, so the scnt reload
   // after START is 1 to keep every later sample point on its nominal tick.
   localparam logic [SW-1:0] RESUME = SW'(1);
   logic [1:0] r_hist;
   logic r_pend;
   logic w_pre;
   assign w_pre = w_tick && r_scnt == w_nom_cnt - 1'b1 && (r_state inside {START, DATA, STOP});
   assign w_dec_en = w_tick && r_pend;
   assign w_dec_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
   always_ff @(posedge clk)
      if (rst || r_state == IDLE || r_state == BRK_WAIT) begin
         r_hist <= '1;
         r_pend <= 1'b0;
      end else if (w_tick) begin
         if (w_pre || w_nom) r_hist <= {r_hist[0], w_rxs};
         r_pend <= w_nom;
      end
`else
   localparam logic [SW-1:0] RESUME = '0;
   assign w_dec_en = w_nom;
   assign w_dec_bit = w_rxs;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_state    <= IDLE;
         r_scnt     <= '0;
         r_idx      <= '0;
         r_shift    <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         r_sync1    <= rx;
         r_sync2    <= r_sync1;
         dout_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (r_state)
            IDLE:
               if (!w_rxs) begin
                  r_state <= START;
                  r_scnt  <= '0;
               end
            START:
               if (w_dec_en) begin
                  r_state <= w_dec_bit ? IDLE : DATA;
                  r_scnt  <= RESUME;
                  r_idx   <= '0;
               end else if (w_tick) r_scnt <= r_scnt + 1'b1;
            DATA: begin
               if (w_tick) r_scnt <= r_scnt + 1'b1;
               if (w_dec_en) begin
                  r_shift[r_idx] <= w_dec_bit;
                  r_idx <= r_idx + 1'b1;
                  if (r_idx == IW'(DATA_BITS - 1)) r_state <= STOP;
               end
            end
            STOP: begin
               if (w_tick) r_scnt <= r_scnt + 1'b1;
               if (w_dec_en) begin
                  dout_valid <= w_dec_bit;
                  frame_err  <= !w_dec_bit;
                  if (w_dec_bit) dout <= r_shift;
                  r_state <= w_dec_bit ? IDLE : BRK_WAIT;
               end
            end
            BRK_WAIT: if (w_rxs) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   assign busy = r_state != IDLE;
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed self-checking bench with a frame-level timing model for uart_rx_byte
module tb_uart_rx_byte;
   localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   // drive edge -> first capture (1) + synchronizer (2) + half start bit + 9 full bits (+1 tick with majority)
   localparam int LAT = 1 + 2 + OS / 2 + 9 * OS + MAJ;
   logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
   logic [7:0] dout;
   logic dout_valid, frame_err, busy;
   typedef struct {int cyc; bit ok; logic [7:0] b;} ev_t;
   ev_t q[$];
   int vcyc[$];
   int cyc = 0, checks = 0, errors = 0, vcnt = 0, fcnt = 0;
   logic [7:0] m_dout = 8'h00;
   uart_rx_byte #(.CLK_FREQ(1_600_000), .BAUD(100_000), .OVERSAMPLE(OS)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .dout(dout),
      .dout_valid(dout_valid),
      .frame_err(frame_err),
      .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask
   always @(posedge clk) begin
      ev_t e;
      bit ev, ev_ok;
      cyc++;
      #1;
      ev = 1'b0;
      ev_ok = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         ev = 1'b1;
         ev_ok = e.ok;
         if (e.ok) m_dout = e.b;
      end
      chk("dout_valid", dout_valid, ev && ev_ok);
      chk("frame_err", frame_err, ev && !ev_ok);
      chk("dout", dout, m_dout);
      if (dout_valid) begin
         vcnt++;
         vcyc.push_back(cyc);
      end
      if (frame_err) fcnt++;
   end
   // Drives one 8N1 frame from a negedge; optional one-clock inverted glitch and mid-frame reset.
   task automatic send(input logic [7:0] b, input logic stop, input logic [7:0] exp_b,
                       input int glitch_at, input int rst_at);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      q.push_back('{cyc + LAT, stop, exp_b});
      for (int t = 0; t < 10 * OS; t++) begin
         if (t == rst_at) begin
            rst = 1'b1;
            q.delete();
            m_dout = 8'h00;
            @(negedge clk);
            rst = 1'b0;
            rx = 1'b1;
            chk("rst_dout", dout, 0);
            chk("rst_valid", dout_valid, 0);
            chk("rst_ferr", frame_err, 0);
            chk("rst_busy", busy, 0);
            return;
         end
         rx = bits[t / OS] ^ (t == glitch_at);
         if (t == 5 * OS) chk("busy_mid", busy, 1);
         @(negedge clk);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_dout", dout, 8'h00);
      chk("reset_valid", dout_valid, 0);
      chk("reset_ferr", frame_err, 0);
      chk("reset_busy", busy, 0);
      repeat (20) @(negedge clk);
      send(8'h68, 1'b1, 8'h68, -1, -1);
      repeat (10) @(negedge clk);
      chk("single_dout", dout, 8'h68);
      chk("single_busy", busy, 0);
      chk("single_vcnt", vcnt, 1);
      chk("single_fcnt", fcnt, 0);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy", busy, 1);
      repeat (7) @(negedge clk);
      chk("glitch_idle", busy, 0);
      repeat (20) @(negedge clk);
      chk("glitch_vcnt", vcnt, 1);
      chk("glitch_fcnt", fcnt, 0);
      send(8'h40, 1'b0, 8'h40, -1, -1);
      repeat (40) @(negedge clk);
      chk("brk_busy", busy, 1);
      chk("brk_fcnt", fcnt, 1);
      chk("brk_vcnt", vcnt, 1);
      chk("brk_dout", dout, 8'h68);
      rx = 1'b1;
      repeat (10) @(negedge clk);
      chk("brk_idle", busy, 0);
      send(8'h68, 1'b1, 8'h68, -1, -1);
      repeat (10) @(negedge clk);
      chk("after_brk_vcnt", vcnt, 2);
      chk("after_brk_dout", dout, 8'h68);
      send(8'h40, 1'b1, 8'h40, -1, -1);
      send(8'h68, 1'b1, 8'h68, -1, -1);
      repeat (10) @(negedge clk);
      chk("b2b_vcnt", vcnt, 4);
      chk("b2b_gap", vcyc[vcyc.size() - 1] - vcyc[vcyc.size() - 2], 160);
      chk("b2b_dout", dout, 8'h68);
      send(8'h68, 1'b1, 8'h68, -1, 70);
      repeat (30) @(negedge clk);
      chk("rstmid_vcnt", vcnt, 4);
      chk("rstmid_fcnt", fcnt, 1);
      send(8'h55, 1'b1, 8'h55, -1, -1);
      repeat (10) @(negedge clk);
      chk("rstmid_next_dout", dout, 8'h55);
      chk("rstmid_next_vcnt", vcnt, 5);
      send(8'h00, 1'b1, MAJ ? 8'h00 : 8'h01, 24, -1);
      repeat (10) @(negedge clk);
      chk("maj_dout", dout, MAJ ? 8'h00 : 8'h01);
      chk("maj_vcnt", vcnt, 6);
      repeat (20) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
